// File: rtl/power_on_lock_bank.sv
// Power-on security lock bank: every channel resets locked and unlocks only on a keyed request.
// Repeated bad requests force a timed lockout; channels can be relocked or made permanent.
module power_on_lock_bank #(
  parameter int NUM_LOCKS      = 4,
  parameter int KEY_WIDTH      = 16,
  parameter logic [NUM_LOCKS*KEY_WIDTH-1:0] KEYS = 64'hD4D4C3C3B2B2A1A1,
  parameter int MAX_FAIL       = 3,
  parameter int LOCKOUT_CYCLES = 16,
  localparam int FW = $clog2(MAX_FAIL + 1),
  localparam int CW = $clog2(LOCKOUT_CYCLES + 1)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [3:0]           req_ch,
  input  logic [KEY_WIDTH-1:0] req_key,
  input  logic [NUM_LOCKS-1:0] relock,
  input  logic [NUM_LOCKS-1:0] perm_lock,
  output logic [NUM_LOCKS-1:0] locked,
  output logic [NUM_LOCKS-1:0] perm,
  output logic                 resp_valid,
  output logic [1:0]           resp_code,
  output logic [FW-1:0]        fail_cnt,
  output logic                 in_lockout,
  output logic [1:0]           dbg_state
);

  // Handshake: a request transfers on a rising edge where req_valid & req_ready are both 1;
  // req_ready is high only in IDLE, so at most one request is in flight and none during lockout.

  typedef enum logic [1:0] {IDLE = 2'd0, CHECK = 2'd1, LOCKOUT = 2'd2} state_t;

  localparam logic [1:0]    RC_OK = 2'b00, RC_BADKEY = 2'b01, RC_PERM = 2'b10, RC_BADCH = 2'b11;
  localparam logic [FW-1:0] MAX_F = FW'(MAX_FAIL);

  state_t                 state_q, state_d;
  logic [3:0]             ch_q, ch_d;
  logic [KEY_WIDTH-1:0]   key_q, key_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [FW-1:0]          fail_q, fail_d, fail_inc;
  logic [NUM_LOCKS-1:0]   locked_q, locked_d, perm_q, perm_d, unlock_mask;
  logic                   resp_v_q, resp_v_d;
  logic [1:0]             code_q, code_d;

  logic [KEY_WIDTH-1:0]   ch_key;
  logic [NUM_LOCKS-1:0]   ch_onehot;
  logic                   ch_perm, ch_bad, is_fail;
  logic [31:0]            ch_wide;

  // Decode the latched channel; an out-of-range index matches no channel.
  always_comb begin
    ch_key    = '0;
    ch_onehot = '0;
    ch_perm   = 1'b0;
    for (int i = 0; i < NUM_LOCKS; i++) begin
      if (ch_q == 4'(i)) begin
        ch_key       = KEYS[i*KEY_WIDTH +: KEY_WIDTH];
        ch_onehot[i] = 1'b1;
        ch_perm      = perm_q[i];
      end
    end
  end

  assign ch_wide  = 32'(ch_q);
  assign ch_bad   = (ch_wide >= 32'(NUM_LOCKS));
  assign fail_inc = (fail_q < MAX_F) ? fail_q + FW'(1) : fail_q;

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    key_d       = key_q;
    cnt_d       = cnt_q;
    fail_d      = fail_q;
    resp_v_d    = 1'b0;
    code_d      = code_q;
    unlock_mask = '0;
    is_fail     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          ch_d    = req_ch;
          key_d   = req_key;
          state_d = CHECK;
        end
      end
      CHECK: begin
        resp_v_d = 1'b1;
        state_d  = IDLE;
        if (ch_bad) begin
          code_d  = RC_BADCH;
          is_fail = 1'b1;
        end else if (ch_perm) begin
          code_d = RC_PERM;
        end else if (key_q != ch_key) begin
          code_d  = RC_BADKEY;
          is_fail = 1'b1;
        end else begin
          code_d      = RC_OK;
          fail_d      = '0;
          unlock_mask = ch_onehot;
        end
        if (is_fail) begin
          fail_d = fail_inc;
          if (fail_inc == MAX_F) begin
            state_d = LOCKOUT;
            cnt_d   = CW'(LOCKOUT_CYCLES);
          end
        end
      end
      LOCKOUT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          fail_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Relock and perm_lock are applied after the unlock so a same-edge lock request wins.
  assign locked_d = (locked_q & ~unlock_mask) | relock | perm_lock;
  assign perm_d   = perm_q | perm_lock;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      ch_q     <= '0;
      key_q    <= '0;
      cnt_q    <= '0;
      fail_q   <= '0;
      locked_q <= '1;
      perm_q   <= '0;
      resp_v_q <= 1'b0;
      code_q   <= RC_OK;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      key_q    <= key_d;
      cnt_q    <= cnt_d;
      fail_q   <= fail_d;
      locked_q <= locked_d;
      perm_q   <= perm_d;
      resp_v_q <= resp_v_d;
      code_q   <= code_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign in_lockout = (state_q == LOCKOUT);
  assign locked     = locked_q;
  assign perm       = perm_q;
  assign resp_valid = resp_v_q;
  assign resp_code  = code_q;
  assign fail_cnt   = fail_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_power_on_lock_bank.sv
// Directed bench for power_on_lock_bank: unlock, bad keys and lockout, perm, relock race, reset abort.
module tb_power_on_lock_bank;

  logic        clk;
  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_ch;
  logic [15:0] req_key;
  logic [3:0]  relock;
  logic [3:0]  perm_lock;
  logic [3:0]  locked;
  logic [3:0]  perm;
  logic        resp_valid;
  logic [1:0]  resp_code;
  logic [1:0]  fail_cnt;
  logic        in_lockout;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;
  logic [1:0] exp_q[$];

  power_on_lock_bank dut (
    .clk        (clk),
    .resetn     (resetn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_ch     (req_ch),
    .req_key    (req_key),
    .relock     (relock),
    .perm_lock  (perm_lock),
    .locked     (locked),
    .perm       (perm),
    .resp_valid (resp_valid),
    .resp_code  (resp_code),
    .fail_cnt   (fail_cnt),
    .in_lockout (in_lockout),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Issue one request (driven and sampled on falling edges); rl is driven so it lands on the result edge.
  task automatic do_req(input logic [3:0] ch, input logic [15:0] key, input logic [3:0] rl,
                        input logic [1:0] exp_code);
    logic [1:0] exp_c;
    int n;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_before", 32'(req_ready), 1);
    exp_q.push_back(exp_code);
    req_valid = 1'b1;
    req_ch    = ch;
    req_key   = key;
    @(negedge clk);
    req_valid = 1'b0;
    relock    = rl;
    check("state_check", 32'(dbg_state), 1);
    check("resp_early", 32'(resp_valid), 0);
    @(negedge clk);
    relock = '0;
    exp_c  = exp_q.pop_front();
    check("resp_valid", 32'(resp_valid), 1);
    check("resp_code", 32'(resp_code), 32'(exp_c));
  endtask

  initial begin
    int n;
    resetn    = 1'b0;
    req_valid = 1'b0;
    req_ch    = '0;
    req_key   = '0;
    relock    = '0;
    perm_lock = '0;
    repeat (2) @(negedge clk);
    check("rst_locked", 32'(locked), 32'hF);
    check("rst_resp_valid", 32'(resp_valid), 0);
    resetn = 1'b1;
    @(negedge clk);
    check("post_rst_locked", 32'(locked), 32'hF);
    check("post_rst_perm", 32'(perm), 0);
    check("post_rst_fail", 32'(fail_cnt), 0);
    check("post_rst_ready", 32'(req_ready), 1);
    check("post_rst_resp", 32'(resp_valid), 0);
    check("post_rst_lockout", 32'(in_lockout), 0);
    check("post_rst_code", 32'(resp_code), 0);

    // good key on channel 1
    do_req(4'd1, 16'hB2B2, 4'h0, 2'b00);
    check("t2_locked", 32'(locked), 32'hD);
    check("t2_fail", 32'(fail_cnt), 0);
    @(negedge clk);
    check("t2_pulse_end", 32'(resp_valid), 0);

    // three bad keys trigger lockout
    for (int k = 1; k <= 3; k++) begin
      do_req(4'd0, 16'h0000, 4'h0, 2'b01);
      check("t3_fail_cnt", 32'(fail_cnt), 32'(k));
    end
    check("t3_in_lockout", 32'(in_lockout), 1);
    check("t3_ready_low", 32'(req_ready), 0);
    n = 0;
    while (in_lockout && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("t3_lockout_len", 32'(n), 16);
    check("t3_fail_clr", 32'(fail_cnt), 0);
    check("t3_ready_back", 32'(req_ready), 1);
    check("t3_locked", 32'(locked), 32'hD);

    // permanent lock on channel 2, then a bad channel
    perm_lock = 4'b0100;
    @(negedge clk);
    perm_lock = '0;
    check("t4_perm", 32'(perm), 32'h4);
    check("t4_locked_a", 32'(locked), 32'hD);
    do_req(4'd2, 16'hC3C3, 4'h0, 2'b10);
    check("t4_locked_b", 32'(locked), 32'hD);
    check("t4_fail_perm", 32'(fail_cnt), 0);
    do_req(4'd7, 16'h1234, 4'h0, 2'b11);
    check("t4_fail_badch", 32'(fail_cnt), 1);
    do_req(4'd0, 16'hA1A1, 4'h0, 2'b00);
    check("t4_locked_c", 32'(locked), 32'hC);
    check("t4_fail_ok", 32'(fail_cnt), 0);

    // relock on the result edge beats the unlock
    do_req(4'd3, 16'hD4D4, 4'b1000, 2'b00);
    check("t5_locked", 32'(locked), 32'hC);
    check("t5_perm", 32'(perm), 32'h4);
    relock = 4'b0001;
    @(negedge clk);
    relock = '0;
    check("t5_relock0", 32'(locked), 32'hD);
    // channel 0 key presented to channel 1 is rejected
    do_req(4'd1, 16'hA1A1, 4'h0, 2'b01);
    check("t5_wrong_ch_key", 32'(locked), 32'hD);
    check("t5_fail", 32'(fail_cnt), 1);

    // reset during CHECK aborts the unlock
    @(negedge clk);
    req_valid = 1'b1;
    req_ch    = 4'd0;
    req_key   = 16'hA1A1;
    @(negedge clk);
    req_valid = 1'b0;
    check("t6_in_check", 32'(dbg_state), 1);
    resetn = 1'b0;
    #1;
    check("t6_async_locked", 32'(locked), 32'hF);
    check("t6_async_state", 32'(dbg_state), 0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("t6_resp", 32'(resp_valid), 0);
    check("t6_locked", 32'(locked), 32'hF);
    check("t6_perm", 32'(perm), 0);
    check("t6_state", 32'(dbg_state), 0);
    check("t6_ready", 32'(req_ready), 1);
    check("t6_fail", 32'(fail_cnt), 0);
    @(negedge clk);
    check("t6_resp_late", 32'(resp_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
